// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse initialisation sequencer: reset, set sample rate, enable reporting,
// with response checking, retries, timeouts, and gating of the stream to the packet parser.
module ps2_mouse_init_ctrl #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          MAX_RETRIES    = 3,
    parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
    localparam int         RW             = $clog2(MAX_RETRIES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    stream_data,
    output logic          stream_valid,
    output logic          stream_en,
    output logic          busy,
    output logic          init_done,
    output logic          init_error,
    output logic [RW-1:0] retry_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_RATE   = 8'hF3;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_BAT = 3'd3,
        ST_WAIT_ID  = 3'd4,
        ST_STREAM   = 3'd5,
        ST_ERROR    = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    stream_data_q;
    logic          stream_valid_q;
    logic          stream_en_q;
    logic          busy_q;
    logic          init_done_q;
    logic          init_error_q;
    logic          fail_s;
    logic          keep_step_s;
    logic          busy_d;

    function automatic logic [7:0] cmd_byte(input logic [1:0] step);
        case (step)
            2'd0:    cmd_byte = CMD_RESET;
            2'd1:    cmd_byte = CMD_RATE;
            2'd2:    cmd_byte = SAMPLE_RATE;
            2'd3:    cmd_byte = CMD_ENABLE;
            default: cmd_byte = CMD_RESET;
        endcase
    endfunction

    // Next-state logic: sequencing, response decoding, timeout and failure handling
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        fail_s      = 1'b0;
        keep_step_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_STREAM, ST_ERROR: begin
                if (start) begin
                    state_d = ST_SEND;
                    step_d  = 2'd0;
                    retry_d = '0;
                    timer_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SEND: begin
                // A handshake on the last timer cycle counts as progress, not a timeout
                if (tx_valid_q && tx_ready) begin
                    state_d    = ST_WAIT_ACK;
                    tx_valid_d = 1'b0;
                    timer_d    = '0;
                end else if (timer_q == TMR_LAST) begin
                    fail_s = 1'b1;
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = cmd_byte(step_q);
                    timer_d    = timer_q + TW'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (rx_data == RSP_ACK) begin
                        case (step_q)
                            2'd0:    state_d = ST_WAIT_BAT;
                            2'd3:    state_d = ST_STREAM;
                            default: begin
                                step_d  = step_q + 2'd1;
                                state_d = ST_SEND;
                            end
                        endcase
                    end else if (rx_data == RSP_RESEND) begin
                        fail_s      = 1'b1;
                        keep_step_s = 1'b1;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    fail_s = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_BAT, ST_WAIT_ID: begin
                if (rx_valid) begin
                    timer_d = '0;
                    if (state_q == ST_WAIT_BAT && rx_data == RSP_BAT_OK) begin
                        state_d = ST_WAIT_ID;
                    end else if (state_q == ST_WAIT_ID && rx_data == RSP_ID) begin
                        state_d = ST_SEND;
                        step_d  = 2'd1;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    fail_s = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail_s) begin
            tx_valid_d = 1'b0;
            timer_d    = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = ST_ERROR;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = ST_SEND;
                step_d  = keep_step_s ? step_q : 2'd0;
            end
        end else begin
            retry_d = retry_d;
        end

        busy_d = (state_d == ST_SEND) || (state_d == ST_WAIT_ACK) ||
                 (state_d == ST_WAIT_BAT) || (state_d == ST_WAIT_ID);
    end

    // State, sequencing registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            step_q         <= 2'd0;
            retry_q        <= '0;
            timer_q        <= '0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            stream_data_q  <= 8'h00;
            stream_valid_q <= 1'b0;
            stream_en_q    <= 1'b0;
            busy_q         <= 1'b0;
            init_done_q    <= 1'b0;
            init_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            busy_q         <= busy_d;
            stream_en_q    <= (state_d == ST_STREAM);
            init_done_q    <= (state_d == ST_STREAM);
            init_error_q   <= (state_d == ST_ERROR);
            // Only bytes received while already streaming reach the parser
            stream_valid_q <= (state_q == ST_STREAM) && rx_valid;
            if ((state_q == ST_STREAM) && rx_valid) begin
                stream_data_q <= rx_data;
            end else begin
                stream_data_q <= stream_data_q;
            end
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign stream_data  = stream_data_q;
    assign stream_valid = stream_valid_q;
    assign stream_en    = stream_en_q;
    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign init_error   = init_error_q;
    assign retry_count  = retry_q;

endmodule
